// File: rtl/wb_write_queue.sv
// wb_write_queue: circular write-back queue draining to a register file, with youngest-entry read forwarding.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic                     hold,
  output logic                     we2,
  output logic [4:0]               wa3,
  output logic [31:0]              wd3,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  input  logic [31:0]              rf_rd1,
  input  logic [31:0]              rf_rd2,
  output logic [31:0]              rd1,
  output logic [31:0]              rd2,
  output logic                     fwd1,
  output logic                     fwd2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic          push;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign push     = in_valid && in_ready && in_addr != 5'd0;
  assign we2      = count != '0 && !hold;
  assign wa3      = count != '0 ? addr_q[head] : '0;
  assign wd3      = count != '0 ? data_q[head] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (we2) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(we2);
    end
  end
  // Payload needs no reset: occupancy is defined by head and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rd1  = rf_rd1;
    rd2  = rf_rd2;
    fwd1 = 1'b0;
    fwd2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < count) begin
        if (addr_q[head + AW'(k)] == ra1) begin
          rd1  = data_q[head + AW'(k)];
          fwd1 = 1'b1;
        end
        if (addr_q[head + AW'(k)] == ra2) begin
          rd2  = data_q[head + AW'(k)];
          fwd2 = 1'b1;
        end
      end
    end
    if (ra1 == 5'd0) begin
      rd1  = '0;
      fwd1 = 1'b0;
    end
    if (ra2 == 5'd0) begin
      rd2  = '0;
      fwd2 = 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] RF1 = 32'h11110000;
  localparam logic [31:0] RF2 = 32'h22220000;

  logic clk = 0, rst_n = 0, in_valid = 0, hold = 0;
  logic in_ready, we2, fwd1, fwd2;
  logic [4:0] in_addr = 0, ra1 = 0, ra2 = 0, wa3;
  logic [31:0] in_data = 0, rf_rd1 = 0, rf_rd2 = 0, wd3, rd1, rd2;
  logic [CW-1:0] count;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .we2(we2), .wa3(wa3),
    .wd3(wd3), .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1(rd1), .rd2(rd2), .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];

  typedef struct {
    logic v; logic [4:0] a; logic [31:0] d; logic h; logic [4:0] r1, r2;
    int cnt; logic rdy, we; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] e1; logic f1; logic [31:0] e2; logic f2;
  } vec_t;
  vec_t tv[11];

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fwd_ref(input logic [4:0] ra, input logic [31:0] rf, output logic [31:0] e, output logic f);
    e = ra == 0 ? 32'h0 : rf;
    f = 0;
    foreach (q[i]) if (ra != 0 && q[i].a == ra) begin e = q[i].d; f = 1; end
  endtask

  task automatic model_check();
    logic [31:0] e1, e2;
    logic f1, f2;
    int n;
    n = q.size();
    fwd_ref(ra1, rf_rd1, e1, f1);
    fwd_ref(ra2, rf_rd2, e2, f2);
    chk("count", 32'(count), 32'(n));
    chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
    chk("we2", 32'(we2), 32'(n != 0 && !hold));
    chk("wa3", 32'(wa3), n != 0 ? 32'(q[0].a) : 32'h0);
    chk("wd3", wd3, n != 0 ? q[0].d : 32'h0);
    chk("rd1", rd1, e1);
    chk("fwd1", 32'(fwd1), 32'(f1));
    chk("rd2", rd2, e2);
    chk("fwd2", 32'(fwd2), 32'(f2));
  endtask

  task automatic model_edge();
    logic p;
    p = in_valid && q.size() != DEPTH && in_addr != 0;
    if (q.size() != 0 && !hold) void'(q.pop_front());
    if (p) q.push_back('{in_addr, in_data});
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] f1, input logic [31:0] f2);
    in_valid = v; in_addr = a; in_data = d; hold = h;
    ra1 = r1; ra2 = r2; rf_rd1 = f1; rf_rd2 = f2;
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h,
                      input logic [4:0] r1, input logic [4:0] r2);
    drive(v, a, d, h, r1, r2, $urandom, $urandom);
    @(negedge clk);
    model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1, 1, 32'hAAAA1111, 0, 1, 0, 0, 1, 0, 0, 0, RF1, 0, 0, 0};
    tv[1]  = '{1, 2, 32'hBBBB2222, 0, 1, 2, 1, 1, 1, 1, 32'hAAAA1111, 32'hAAAA1111, 1, RF2, 0};
    tv[2]  = '{0, 0, 0, 0, 1, 2, 1, 1, 1, 2, 32'hBBBB2222, RF1, 0, 32'hBBBB2222, 1};
    tv[3]  = '{0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, RF1, 0, RF2, 0};
    tv[4]  = '{1, 3, 32'h11111111, 1, 3, 4, 0, 1, 0, 0, 0, RF1, 0, RF2, 0};
    tv[5]  = '{1, 3, 32'h22222222, 1, 3, 4, 1, 1, 0, 3, 32'h11111111, 32'h11111111, 1, RF2, 0};
    tv[6]  = '{0, 0, 0, 1, 3, 4, 2, 1, 0, 3, 32'h11111111, 32'h22222222, 1, RF2, 0};
    tv[7]  = '{1, 0, 32'h12345678, 1, 0, 4, 2, 1, 0, 3, 32'h11111111, 0, 0, RF2, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 4, 2, 1, 1, 3, 32'h11111111, 0, 0, RF2, 0};
    tv[9]  = '{0, 0, 0, 0, 3, 4, 1, 1, 1, 3, 32'h22222222, 32'h22222222, 1, RF2, 0};
    tv[10] = '{0, 0, 0, 0, 3, 4, 0, 1, 0, 0, 0, RF1, 0, RF2, 0};

    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_we2", 32'(we2), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", wd3, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].a, tv[i].d, tv[i].h, tv[i].r1, tv[i].r2, RF1, RF2);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_we2", i), 32'(we2), 32'(tv[i].we));
      chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(tv[i].wa));
      chk($sformatf("v%0d_wd3", i), wd3, tv[i].wd);
      chk($sformatf("v%0d_rd1", i), rd1, tv[i].e1);
      chk($sformatf("v%0d_fwd1", i), 32'(fwd1), 32'(tv[i].f1));
      chk($sformatf("v%0d_rd2", i), rd2, tv[i].e2);
      chk($sformatf("v%0d_fwd2", i), 32'(fwd2), 32'(tv[i].f2));
      model_edge();
      @(posedge clk);
      #1;
    end

    // Fill under hold, one extra push must stall, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 5'(5 + i), $urandom, 1, 5'(5 + i), 7);
    @(negedge clk);
    chk("full_count", 32'(count), DEPTH);
    chk("full_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 5, 8);

    // Streaming push/pop with pointer wrap.
    for (int i = 1; i <= 3 * DEPTH; i++) step(1, 5'(i), $urandom, 0, 5'(i), 5'(i - 1));
    step(0, 0, 0, 0, 12, 11);

    // Asynchronous reset with pending entries.
    for (int i = 0; i < 3; i++) step(1, 5'(10 + i), $urandom, 1, 10, 11);
    hold = 0; in_valid = 0; ra1 = 10;
    #1;
    chk("pre_rst_fwd1", 32'(fwd1), 1);
    rst_n = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_we2", 32'(we2), 0);
    chk("arst_fwd1", 32'(fwd1), 0);
    chk("arst_ready", 32'(in_ready), 1);
    q.delete();
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 10, 12);
    step(1, 13, 32'hCAFE0013, 0, 13, 10);
    step(0, 0, 0, 0, 13, 10);
    step(0, 0, 0, 0, 13, 10);

    // Random traffic with a small address range to force collisions.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
